mult32x32_sequencer: RTL and testbench

//  Upstream operand sequencer for the 32x32 multiplier FSM+datapath pair. Buffers (A,B) operand

---
 rtl/mult32x32_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_mult32x32_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult32x32_sequencer.sv
// ---------------------------------------------------------------------------
// mult32x32_sequencer
//
// Operand sequencer sitting in front of the 32x32 multiplier FSM/datapath.
// Operand pairs are queued in a small FIFO. The head pair is presented on
// mul_a/mul_b and the multiplier is started. When the multiplier reports
// completion, the 64-bit product is captured into a valid/ready output slot.
// Only one operation is in flight at a time.
//
// Optional feature: define MULT_WDOG_EN to enable a RUN-phase watchdog. When
// it fires, the op is dropped and err_wdog sets until reset. Without the
// macro, err_wdog is tied low and RUN waits indefinitely.
//
// Parameters
//   FIFO_DEPTH   operand FIFO entries (power of 2, >= 2)
//   WDOG_CYCLES  RUN-phase cycle limit (only used with MULT_WDOG_EN)
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   in_valid/in_ready        operand push handshake (in_ready = FIFO not full)
//   in_a, in_b               operand pair
//   mul_start                to multiplier, high for the whole operation
//   mul_busy                 from multiplier
//   mul_a, mul_b             FIFO head operands
//   mul_product              multiplier product register
//   out_valid/out_ready      result handshake
//   out_product              captured product
//   err_wdog                 sticky watchdog error
// ---------------------------------------------------------------------------
module mult32x32_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WDOG_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_start,
  input  logic        mul_busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        err_wdog
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Reject configurations the pointer arithmetic cannot support.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WDOG_CYCLES < 1) begin : g_param_check
    $error("mult32x32_sequencer: invalid FIFO_DEPTH or WDOG_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, SETTLE} state_t;

  state_t          state_reg, state_next;
  logic            mul_start_reg, mul_start_next;
  logic            seen_busy_reg, seen_busy_next;
  logic            out_valid_reg;
  logic [63:0]     out_product_reg;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     fifo_a_reg [FIFO_DEPTH];
  logic [31:0]     fifo_b_reg [FIFO_DEPTH];
  logic            full, empty, push, pop, capture, wdog_expired;

  assign full     = (count_reg == CW'(FIFO_DEPTH));
  assign empty    = (count_reg == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  // Head of the FIFO is always visible; it only moves on a pop.
  assign mul_a       = fifo_a_reg[rd_ptr_reg];
  assign mul_b       = fifo_b_reg[rd_ptr_reg];
  assign mul_start   = mul_start_reg;
  assign out_valid   = out_valid_reg;
  assign out_product = out_product_reg;

  // ---------------- operand storage ----------------
  // Register-based entries so the head reads as zero straight out of reset.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        fifo_a_reg[gi] <= '0;
        fifo_b_reg[gi] <= '0;
      end else if (push && wr_ptr_reg == PW'(gi)) begin
        fifo_a_reg[gi] <= in_a;
        fifo_b_reg[gi] <= in_b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  // ---------------- watchdog ----------------
`ifdef MULT_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES) + 1;
  logic [WCW-1:0] wdog_cnt_reg;
  logic           err_wdog_reg;
  logic           wdog_fire;

  assign wdog_expired = (wdog_cnt_reg == WCW'(WDOG_CYCLES - 1));
  // Completion on the same edge takes priority over the timeout.
  assign wdog_fire    = (state_reg == RUN) && !(seen_busy_reg && !mul_busy) && wdog_expired;
  assign err_wdog     = err_wdog_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_reg <= '0;
      err_wdog_reg <= 1'b0;
    end else begin
      if (state_reg == LAUNCH)   wdog_cnt_reg <= '0;
      else if (state_reg == RUN) wdog_cnt_reg <= wdog_cnt_reg + WCW'(1);
      if (wdog_fire) err_wdog_reg <= 1'b1;
    end
  end
`else
  assign wdog_expired = 1'b0;
  assign err_wdog     = 1'b0;
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mul_start_reg <= 1'b0;
      seen_busy_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mul_start_reg <= mul_start_next;
      seen_busy_reg <= seen_busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mul_start_next = mul_start_reg;
    seen_busy_next = seen_busy_reg;
    pop            = 1'b0;
    capture        = 1'b0;
    case (state_reg)
      IDLE: begin
        // Launch only when the output slot will be free by capture time.
        if (!empty && (!out_valid_reg || out_ready)) begin
          state_next     = LAUNCH;
          mul_start_next = 1'b1;
        end
      end
      LAUNCH: begin
        seen_busy_next = 1'b0;
        state_next     = RUN;
      end
      RUN: begin
        if (mul_busy) seen_busy_next = 1'b1;
        // busy seen and now low: multiplier has reached its final state.
        if (seen_busy_reg && !mul_busy) begin
          state_next     = SETTLE;
          mul_start_next = 1'b0;
        end else if (wdog_expired) begin
          state_next     = IDLE;
          mul_start_next = 1'b0;
          pop            = 1'b1;
        end
      end
      SETTLE: begin
        capture    = 1'b1;
        pop        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output slot ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg   <= 1'b0;
      out_product_reg <= '0;
    end else if (capture) begin
      out_valid_reg   <= 1'b1;
      out_product_reg <= mul_product;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult32x32_sequencer.sv
// Testbench for mult32x32_sequencer: a 7-busy-cycle multiplier model, a
// queue-based scoreboard checked every cycle, and directed plus random stimulus.
module tb_mult32x32_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        mul_start, mul_busy;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_product;
  logic        out_valid, out_ready;
  logic [63:0] out_product;
  logic        err_wdog;

  always #5 clk = ~clk;

  mult32x32_sequencer #(.FIFO_DEPTH(4), .WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_busy(mul_busy), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .err_wdog(err_wdog)
  );

  // Multiplier environment: busy for 7 cycles after seeing start, then holds
  // the product while start is high; clears it when start drops.
  logic       dead;   // when set the multiplier never goes busy
  logic [2:0] mcnt;
  logic [1:0] mstate;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstate <= 2'd0; mul_busy <= 1'b0; mul_product <= '0; mcnt <= '0;
    end else begin
      case (mstate)
        2'd0: if (mul_start && !dead) begin
          mstate <= 2'd1; mul_busy <= 1'b1; mcnt <= 3'd6;
        end
        2'd1: if (mcnt == 3'd0) begin
          mul_busy <= 1'b0; mul_product <= {32'b0, mul_a} * {32'b0, mul_b}; mstate <= 2'd2;
        end else mcnt <= mcnt - 3'd1;
        default: if (!mul_start) begin
          mstate <= 2'd0; mul_product <= '0;
        end
      endcase
    end
  end

  int checks = 0;
  int failures = 0;
  int accepts = 0;
  int handshakes = 0;
  logic err_seen = 1'b0;

  typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
  pair_t q[$];   // accepted and not yet delivered, oldest first

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every cycle, outputs must agree with the queue of accepted ops.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      accepts = 0;
      handshakes = 0;
    end else begin
      int idx;
      if (err_wdog && !err_seen) begin
        err_seen = 1'b1;
        if (q.size() > 0) void'(q.pop_front());
      end
      // One entry sits in the output slot when out_valid; the rest occupy the FIFO.
      chk("in_ready", {63'b0, in_ready}, {63'b0, (q.size() - int'(out_valid)) < 4});
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_result", {63'b0, out_valid}, 64'd0);
        else chk("out_product", out_product, {32'b0, q[0].a} * {32'b0, q[0].b});
      end
      if (mul_start) begin
        idx = out_valid ? 1 : 0;
        if (q.size() <= idx) chk("spurious_start", {63'b0, mul_start}, 64'd0);
        else begin
          chk("mul_a", {32'b0, mul_a}, {32'b0, q[idx].a});
          chk("mul_b", {32'b0, mul_b}, {32'b0, q[idx].b});
        end
      end
`ifndef MULT_WDOG_EN
      chk("err_wdog_off", {63'b0, err_wdog}, 64'd0);
`endif
      if (out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        handshakes++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{a: in_a, b: in_b});
        accepts++;
      end
    end
  end

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one pair, holding it until accepted (bounded).
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    int k;
    logic acc;
    k = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    do begin
      acc = in_ready;
      step();
      k++;
    end while (!acc && k < 40);
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_out_valid(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 60) begin step(); k++; end
    if (!out_valid) chk(name, 64'd0, 64'd1);
  endtask

  task automatic wait_drained(input string name);
    int k;
    k = 0;
    while (handshakes != accepts && k < 300) begin step(); k++; end
    chk(name, 64'(handshakes), 64'(accepts));
  endtask

  initial begin
    int n;
    int target;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; dead = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_mul_start", {63'b0, mul_start}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_product", out_product, 64'd0);
    chk("rst_mul_a", {32'b0, mul_a}, 64'd0);
    chk("rst_mul_b", {32'b0, mul_b}, 64'd0);
    chk("rst_err_wdog", {63'b0, err_wdog}, 64'd0);
    reset = 1'b0;
    step();

    // Single op and latency from the accept edge.
    in_valid = 1'b1; in_a = 32'd3; in_b = 32'd5;
    step();                          // accept edge E0
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("latency", 64'(n), 64'd11);
    chk("single_product", out_product, 64'h0000_0000_0000_000F);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("single_consumed", {63'b0, out_valid}, 64'd0);

    // Max operands.
    push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out_valid("max_timeout");
    chk("max_product", out_product, 64'hFFFF_FFFE_0000_0001);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // FIFO full with backpressure.
    target = handshakes + 5;
    for (int i = 0; i < 4; i++) push_pair(rnd_op(), rnd_op());
    chk("full_in_ready", {63'b0, in_ready}, 64'd0);
    push_pair(rnd_op(), rnd_op());   // accepted once the first op pops
    n = 0;
    for (int i = 0; i < 30; i++) begin step(); if (mul_start) n++; end
    chk("bp_no_launch", 64'(n), 64'd0);
    chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
    out_ready = 1'b1;
    n = 0;
    while (handshakes < target && n < 200) begin step(); n++; end
    chk("full_results", 64'(handshakes), 64'(target));
    out_ready = 1'b0;

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_a = rnd_op(); in_b = rnd_op();
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drained("random_drain");

    // Reset in the middle of an operation.
    for (int i = 0; i < 4; i++) push_pair(rnd_op(), rnd_op());
    repeat (3) step();
    chk("pre_rst_mul_start", {63'b0, mul_start}, 64'd1);
    chk("pre_rst_in_ready", {63'b0, in_ready}, 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mul_start", {63'b0, mul_start}, 64'd0);
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    step();
    reset = 1'b0;
    step();
    push_pair(32'd7, 32'd9);
    wait_out_valid("post_rst_timeout");
    chk("post_rst_product", out_product, 64'd63);
    wait_drained("post_rst_drain");

`ifdef MULT_WDOG_EN
    // Multiplier never goes busy: watchdog drops the op.
    out_ready = 1'b1;
    dead = 1'b1;
    push_pair(32'd11, 32'd13);
    n = 0;
    for (int i = 0; i < 60 && !err_wdog; i++) begin if (mul_start) n++; step(); end
    if (mul_start) n++;
    chk("wdog_start_cycles", 64'(n), 64'd17);
    chk("wdog_err", {63'b0, err_wdog}, 64'd1);
    chk("wdog_mul_start", {63'b0, mul_start}, 64'd0);
    repeat (5) step();
    chk("wdog_no_result", {63'b0, out_valid}, 64'd0);
    dead = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
